// File: rtl/cnt_ud_eo_checker_pkg.sv
// -----------------------------------------------------------------------------
// cnt_chk_pkg
// Shared definitions for the up/down even/odd counter sequence checker:
//   - chk_state_e   : checker lock state (UNLOCKED, ARMED, TRACK)
//   - CTRL_*        : bit positions of the {preset, ud, oe} control word
//   - PRESET_VAL_DEF: default value the counter loads on preset
// -----------------------------------------------------------------------------
package cnt_chk_pkg;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_ARMED    = 2'd1,
      ST_TRACK    = 2'd2
   } chk_state_e;

   // Control word layout: {preset, ud, oe}
   localparam int CTRL_W      = 3;
   localparam int CTRL_PRESET = 2;
   localparam int CTRL_UD     = 1;
   localparam int CTRL_OE     = 0;

   localparam int PRESET_VAL_DEF = 10;

endpackage : cnt_chk_pkg

// File: rtl/cnt_ud_eo_checker_if.sv
// -----------------------------------------------------------------------------
// cnt_ud_eo_checker_if
// Bundles the checker's sample/control inputs and status outputs.
//   master : the side that drives samples (bench / SoC wrapper)
//   slave  : the checker itself
// Signals:
//   en, ud, oe, preset, cnt_in, clr           : sample and control (to checker)
//   locked, err, err_count, expected, err_sticky : status (from checker)
// -----------------------------------------------------------------------------
interface cnt_ud_eo_checker_if #(
   parameter int WIDTH     = 4,
   parameter int ERR_CNT_W = 8
);
   logic                 en;
   logic                 ud;
   logic                 oe;
   logic                 preset;
   logic [WIDTH-1:0]     cnt_in;
   logic                 clr;
   logic                 locked;
   logic                 err;
   logic [ERR_CNT_W-1:0] err_count;
   logic [WIDTH-1:0]     expected;
   logic                 err_sticky;

   modport master (
      output en, ud, oe, preset, cnt_in, clr,
      input  locked, err, err_count, expected, err_sticky
   );

   modport slave (
      input  en, ud, oe, preset, cnt_in, clr,
      output locked, err, err_count, expected, err_sticky
   );
endinterface : cnt_ud_eo_checker_if

// File: rtl/cnt_ud_eo_checker_step_predict.sv
// -----------------------------------------------------------------------------
// cnt_step_predict
// Purely combinational next-value predictor for the up/down even/odd counter.
// Ports:
//   prev_i : previously observed counter value
//   ctrl_i : control word {preset, ud, oe} that accompanied prev_i
//   next_o : predicted next counter value (modulo 2^WIDTH)
// -----------------------------------------------------------------------------
module cnt_step_predict
   import cnt_chk_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int PRESET_VAL = PRESET_VAL_DEF
) (
   input  logic [WIDTH-1:0]  prev_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   output logic [WIDTH-1:0]  next_o
);

   logic             on_seq;
   logic [WIDTH-1:0] step;

   always_comb begin
      // A value already on the selected parity advances by two to stay on it;
      // an off-parity value needs a single step to get back onto it.
      on_seq = (prev_i[0] == ctrl_i[CTRL_OE]);
      step   = on_seq ? WIDTH'(2) : WIDTH'(1);
      if (ctrl_i[CTRL_PRESET]) begin
         next_o = WIDTH'(PRESET_VAL);
      end else if (ctrl_i[CTRL_UD]) begin
         next_o = prev_i + step;
      end else begin
         next_o = prev_i - step;
      end
   end

endmodule : cnt_step_predict

// File: rtl/cnt_ud_eo_checker.sv
// -----------------------------------------------------------------------------
// cnt_ud_eo_checker
// Sequence checker for the up/down even/odd counter. Each enabled sample is
// compared against the value predicted from the previous sample; mismatches
// while locked raise a one-cycle err pulse and bump a saturating counter.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : cnt_ud_eo_checker_if.slave (en, ud, oe, preset, cnt_in, clr in;
//         locked, err, err_count, expected, err_sticky out)
// Build option:
//   CHK_STICKY_EN - when defined, err_sticky latches any err pulse until clr
//                   or reset; otherwise err_sticky is constant 0.
// -----------------------------------------------------------------------------
module cnt_ud_eo_checker
   import cnt_chk_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int PRESET_VAL = PRESET_VAL_DEF,
   parameter int ERR_CNT_W  = 8
) (
   input logic                 clk,
   input logic                 rst,
   cnt_ud_eo_checker_if.slave  bus
);

   chk_state_e           state_q, state_d;
   logic [WIDTH-1:0]     prev_q;
   logic [CTRL_W-1:0]    prev_ctrl_q;
   logic [CTRL_W-1:0]    ctrl_in;
   logic                 err_q, err_d;
   logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
   logic [WIDTH-1:0]     pred;
   logic                 match;

   always_comb begin
      ctrl_in              = '0;
      ctrl_in[CTRL_PRESET] = bus.preset;
      ctrl_in[CTRL_UD]     = bus.ud;
      ctrl_in[CTRL_OE]     = bus.oe;
   end

   cnt_step_predict #(
      .WIDTH      (WIDTH),
      .PRESET_VAL (PRESET_VAL)
   ) u_predict (
      .prev_i (prev_q),
      .ctrl_i (prev_ctrl_q),
      .next_o (pred)
   );

   assign match = (bus.cnt_in == pred);

   // Next state, error pulse and error counter
   always_comb begin
      state_d     = state_q;
      err_d       = 1'b0;
      err_count_d = err_count_q;
      if (bus.en) begin
         case (state_q)
            ST_UNLOCKED: state_d = ST_ARMED;
            ST_ARMED:    if (match) state_d = ST_TRACK;
            ST_TRACK: begin
               if (!match) begin
                  state_d = ST_ARMED;
                  err_d   = 1'b1;
               end
            end
            default:     state_d = ST_UNLOCKED;
         endcase
      end
      if (err_d && (err_count_q != {ERR_CNT_W{1'b1}})) begin
         err_count_d = err_count_q + 1'b1;
      end
      // Clear takes precedence over a same-edge increment
      if (bus.clr) begin
         err_count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_UNLOCKED;
         prev_q      <= '0;
         prev_ctrl_q <= '0;
         err_q       <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
         if (bus.en) begin
            prev_q      <= bus.cnt_in;
            prev_ctrl_q <= ctrl_in;
         end
      end
   end

   // The prediction is a function of registered prev/prev_ctrl only, so it
   // changes exactly on sample edges. It reads 0 until a first sample exists;
   // the checker never returns to UNLOCKED except through reset.
   assign bus.expected  = (state_q == ST_UNLOCKED) ? '0 : pred;
   assign bus.locked    = (state_q == ST_TRACK);
   assign bus.err       = err_q;
   assign bus.err_count = err_count_q;

`ifdef CHK_STICKY_EN
   logic err_sticky_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_sticky_q <= 1'b0;
      end else if (bus.clr) begin
         err_sticky_q <= 1'b0;
      end else if (err_d) begin
         err_sticky_q <= 1'b1;
      end
   end

   assign bus.err_sticky = err_sticky_q;
`else
   assign bus.err_sticky = 1'b0;
`endif

endmodule : cnt_ud_eo_checker

// File: tb/tb_cnt_ud_eo_checker.sv
// -----------------------------------------------------------------------------
// tb_cnt_ud_eo_checker
// Randomised and directed bench for cnt_ud_eo_checker with a behavioural
// model: lock status is "previous sample existed and this one matched", an
// error is "was locked and this one mismatched".
// -----------------------------------------------------------------------------
module tb_cnt_ud_eo_checker;

   localparam int W    = 4;
   localparam int CW   = 2;
   localparam int PV   = 10;
   localparam int MOD  = 16;
   localparam int CMAX = 3;
`ifdef CHK_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic clk;
   logic rst;

   cnt_ud_eo_checker_if #(.WIDTH(W), .ERR_CNT_W(CW)) bus ();

   cnt_ud_eo_checker #(
      .WIDTH      (W),
      .PRESET_VAL (PV),
      .ERR_CNT_W  (CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model state
   bit m_have_prev;
   int m_prev;
   bit m_pre, m_ud, m_oe;
   bit m_locked;
   bit m_err;
   int m_cnt;
   bit m_sticky;

   function automatic int model_next(int prev, bit pre, bit ud, bit oe);
      int step;
      if (pre) return PV;
      step = ((prev % 2) == int'(oe)) ? 2 : 1;
      return (prev + MOD + (ud ? step : -step)) % MOD;
   endfunction

   function automatic int model_exp();
      return m_have_prev ? model_next(m_prev, m_pre, m_ud, m_oe) : 0;
   endfunction

   // Apply one clock edge of stimulus and advance the model. No checking here.
   task automatic drive(bit en, bit ud, bit oe, bit pre, int cnt, bit clr);
      bit match;
      bus.en     = en;
      bus.ud     = ud;
      bus.oe     = oe;
      bus.preset = pre;
      bus.cnt_in = W'(cnt);
      bus.clr    = clr;
      @(posedge clk);
      m_err = 1'b0;
      if (en) begin
         if (m_have_prev) begin
            match    = (cnt == model_exp());
            m_err    = m_locked && !match;
            m_locked = match;
         end else begin
            m_locked = 1'b0;
         end
         m_have_prev = 1'b1;
         m_prev      = cnt;
         m_pre       = pre;
         m_ud        = ud;
         m_oe        = oe;
      end
      if (m_err) begin
         m_cnt    = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
         m_sticky = 1'b1;
      end
      if (clr) begin
         m_cnt    = 0;
         m_sticky = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      bus.en = 0; bus.ud = 0; bus.oe = 0; bus.preset = 0; bus.cnt_in = '0; bus.clr = 0;
      @(negedge clk);
      rst = 1'b0;
      #2;
      m_have_prev = 0; m_prev = 0; m_pre = 0; m_ud = 0; m_oe = 0;
      m_locked = 0; m_err = 0; m_cnt = 0; m_sticky = 0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      // Build up some state, then assert reset away from any clock edge
      do_reset();
      drive(1, 1, 1, 0, 3, 0);
      drive(1, 1, 1, 0, 5, 0);
      drive(1, 1, 1, 0, 8, 0);
      #2;
      rst = 1'b0;
      #1;
      n_vec++;
      if (bus.locked !== 1'b0 || bus.err !== 1'b0 || bus.err_count !== '0 ||
          bus.expected !== '0 || bus.err_sticky !== 1'b0) begin
         n_bad++;
         $display("FAIL reset: locked=%b err=%b cnt=%0d exp=%0d sticky=%b, required all 0",
                  bus.locked, bus.err, bus.err_count, bus.expected, bus.err_sticky);
      end
      do_reset();
      n_vec++;
      if (bus.locked !== 1'b0 || bus.expected !== '0) begin
         n_bad++;
         $display("FAIL reset_release: locked=%b exp=%0d, required 0/0", bus.locked, bus.expected);
      end
   endtask

   task automatic test_lock_up_odd();
      do_reset();
      drive(1, 1, 1, 0, 3, 0);
      n_vec++;
      if (bus.locked !== 1'b0 || bus.expected !== W'(5)) begin
         n_bad++;
         $display("FAIL lock_first: locked=%b exp=%0d, required 0/5", bus.locked, bus.expected);
      end
      drive(1, 1, 1, 0, 5, 0);
      n_vec++;
      if (bus.locked !== 1'b1 || bus.err !== 1'b0) begin
         n_bad++;
         $display("FAIL lock_on_5: locked=%b err=%b, required 1/0", bus.locked, bus.err);
      end
      drive(1, 1, 1, 0, 7, 0);
      n_vec++;
      if (bus.locked !== 1'b1 || bus.err !== 1'b0 || bus.expected !== W'(9)) begin
         n_bad++;
         $display("FAIL lock_exp9: locked=%b err=%b exp=%0d, required 1/0/9",
                  bus.locked, bus.err, bus.expected);
      end
   endtask

   task automatic test_even_wrap();
      int seq [4] = '{12, 14, 0, 2};
      do_reset();
      foreach (seq[i]) begin
         drive(1, 1, 0, 0, seq[i], 0);
         n_vec++;
         if (bus.err !== 1'b0 || bus.locked !== (i > 0)) begin
            n_bad++;
            $display("FAIL even_wrap[%0d]: err=%b locked=%b, required 0/%0b",
                     i, bus.err, bus.locked, (i > 0));
         end
      end
      n_vec++;
      if (bus.expected !== W'(4)) begin
         n_bad++;
         $display("FAIL even_wrap_exp: exp=%0d, required 4", bus.expected);
      end
   endtask

   task automatic test_injected_error();
      do_reset();
      drive(1, 0, 0, 0, 8, 0);
      drive(1, 0, 0, 0, 6, 0);
      drive(1, 0, 0, 0, 5, 0);
      n_vec++;
      if (bus.err !== 1'b1 || bus.err_count !== CW'(1) || bus.locked !== 1'b0 ||
          bus.err_sticky !== STICKY) begin
         n_bad++;
         $display("FAIL inject_err: err=%b cnt=%0d locked=%b sticky=%b, required 1/1/0/%b",
                  bus.err, bus.err_count, bus.locked, bus.err_sticky, STICKY);
      end
      drive(1, 0, 0, 0, 3, 0);   // 5 predicts 4: mismatch while ARMED
      n_vec++;
      if (bus.err !== 1'b0 || bus.locked !== 1'b0 || bus.err_count !== CW'(1)) begin
         n_bad++;
         $display("FAIL armed_mismatch: err=%b locked=%b cnt=%0d, required 0/0/1",
                  bus.err, bus.locked, bus.err_count);
      end
      drive(1, 0, 0, 0, 2, 0);
      n_vec++;
      if (bus.locked !== 1'b1 || bus.err !== 1'b0) begin
         n_bad++;
         $display("FAIL relock: locked=%b err=%b, required 1/0", bus.locked, bus.err);
      end
   endtask

   task automatic test_preset();
      do_reset();
      drive(1, 1, 1, 0, 3, 0);
      drive(1, 1, 1, 0, 5, 0);
      drive(1, 1, 1, 1, 7, 0);
      n_vec++;
      if (bus.expected !== W'(PV)) begin
         n_bad++;
         $display("FAIL preset_exp: exp=%0d, required %0d", bus.expected, PV);
      end
      drive(1, 1, 1, 0, 10, 0);
      n_vec++;
      if (bus.err !== 1'b0 || bus.locked !== 1'b1) begin
         n_bad++;
         $display("FAIL preset_match: err=%b locked=%b, required 0/1", bus.err, bus.locked);
      end
   endtask

   task automatic test_en_gap();
      do_reset();
      drive(1, 1, 1, 0, 1, 0);
      drive(1, 1, 1, 0, 3, 0);
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 1, 0, 9, 0);
         n_vec++;
         if (bus.locked !== 1'b1 || bus.err !== 1'b0 || bus.expected !== W'(5)) begin
            n_bad++;
            $display("FAIL en_gap[%0d]: locked=%b err=%b exp=%0d, required 1/0/5",
                     i, bus.locked, bus.err, bus.expected);
         end
      end
      drive(1, 1, 1, 0, 5, 0);
      n_vec++;
      if (bus.err !== 1'b0 || bus.locked !== 1'b1) begin
         n_bad++;
         $display("FAIL en_gap_resume: err=%b locked=%b, required 0/1", bus.err, bus.locked);
      end
   endtask

   task automatic test_sat_clr();
      do_reset();
      drive(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 0, 0, model_exp(), 0);                 // lock
         drive(1, 1, 0, 0, (model_exp() + 1) % MOD, 0);     // inject
         n_vec++;
         if (bus.err !== 1'b1 || bus.err_count !== CW'(i < 3 ? i + 1 : 3)) begin
            n_bad++;
            $display("FAIL sat[%0d]: err=%b cnt=%0d, required 1/%0d",
                     i, bus.err, bus.err_count, (i < 3 ? i + 1 : 3));
         end
      end
      n_vec++;
      if (bus.err_sticky !== STICKY) begin
         n_bad++;
         $display("FAIL sticky_set: sticky=%b, required %b", bus.err_sticky, STICKY);
      end
      drive(0, 1, 0, 0, 0, 1);
      n_vec++;
      if (bus.err_count !== '0 || bus.err_sticky !== 1'b0 || bus.err !== 1'b0) begin
         n_bad++;
         $display("FAIL clr: cnt=%0d sticky=%b err=%b, required 0/0/0",
                  bus.err_count, bus.err_sticky, bus.err);
      end
      // clr coinciding with a mismatch: pulse still fires, count stays clear
      drive(1, 1, 0, 0, model_exp(), 0);
      drive(1, 1, 0, 0, (model_exp() + 1) % MOD, 1);
      n_vec++;
      if (bus.err !== 1'b1 || bus.err_count !== '0 || bus.err_sticky !== 1'b0) begin
         n_bad++;
         $display("FAIL clr_vs_err: err=%b cnt=%0d sticky=%b, required 1/0/0",
                  bus.err, bus.err_count, bus.err_sticky);
      end
   endtask

   task automatic test_random();
      bit en, ud, oe, pre, clr;
      int cnt;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         en  = ($urandom_range(0, 9) != 0);
         ud  = $urandom_range(0, 1);
         oe  = $urandom_range(0, 1);
         pre = ($urandom_range(0, 9) == 0);
         clr = ($urandom_range(0, 19) == 0);
         cnt = ($urandom_range(0, 3) != 0) ? model_exp() : int'($urandom_range(0, MOD - 1));
         drive(en, ud, oe, pre, cnt, clr);
         n_vec++;
         if (bus.locked !== m_locked || bus.err !== m_err || bus.err_count !== CW'(m_cnt) ||
             bus.expected !== W'(model_exp()) || bus.err_sticky !== (STICKY & m_sticky)) begin
            n_bad++;
            $display("FAIL random[%0d]: locked=%b err=%b cnt=%0d exp=%0d sticky=%b, required %b/%b/%0d/%0d/%b",
                     i, bus.locked, bus.err, bus.err_count, bus.expected, bus.err_sticky,
                     m_locked, m_err, m_cnt, model_exp(), STICKY & m_sticky);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.en = 0; bus.ud = 0; bus.oe = 0; bus.preset = 0; bus.cnt_in = '0; bus.clr = 0;
      test_reset();
      test_lock_up_odd();
      test_even_wrap();
      test_injected_error();
      test_preset();
      test_en_gap();
      test_sat_clr();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_cnt_ud_eo_checker
